// File: rtl/pmem_responder_if.sv
// Wishbone-style line bus between a master and pmem_responder.
// The master drives the request fields; the responder returns data, ACK and busy.
interface pmem_responder_if #(
   parameter int ADDR_W = 12
);
   logic              CYC;
   logic              STB;
   logic              WE;
   logic [ADDR_W-1:0] ADR;
   logic [15:0]       SEL;
   logic [127:0]      DAT_M;
   logic [127:0]      DAT_S;
   logic              ACK;
   logic              busy;

   modport master (
      output CYC, STB, WE, ADR, SEL, DAT_M,
      input  DAT_S, ACK, busy
   );

   modport slave (
      input  CYC, STB, WE, ADR, SEL, DAT_M,
      output DAT_S, ACK, busy
   );
endinterface

// File: rtl/pmem_responder.sv
// Fixed-latency 128-bit line memory responder.
// A request is latched on acceptance, the access happens on the edge that
// enters DONE, and ACK is a single-cycle pulse. Dropping CYC while waiting
// aborts the request with no side effects. The array is built from sixteen
// byte-wide lanes so SEL maps straight onto per-lane write enables.

// One byte column of the line array; contents are never reset.
module pmem_byte_lane #(
   parameter int ADDR_W = 12
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] adr,
   input  logic [7:0]        wdata,
   output logic [7:0]        rdata
);
   logic [7:0] mem [2**ADDR_W];

   // byte write on the DONE-entry edge when this lane is enabled
   always_ff @(posedge clk) begin
      if (we) mem[adr] <= wdata;
   end

   assign rdata = mem[adr];
endmodule

module pmem_responder #(
   parameter int LATENCY = 4,
   parameter int ADDR_W  = 12
) (
   input  logic            clk,
   input  logic            rst,
   pmem_responder_if.slave bus
);
   localparam int LANES = 16;

   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

   state_t            state, state_nx;
   logic [7:0]        cnt, cnt_nx;
   logic              req;
   logic              accept;
   logic              enter_done;

   // request fields captured at acceptance
   logic              lat_we;
   logic [ADDR_W-1:0] lat_adr;
   logic [15:0]       lat_sel;
   logic [127:0]      lat_dat;

   // fields of the request being completed; with LATENCY=1 the DONE-entry
   // edge is the accepting edge, so the live bus values are used then
   logic              op_we;
   logic [ADDR_W-1:0] op_adr;
   logic [15:0]       op_sel;
   logic [LANES-1:0][7:0] op_dat;
   logic [LANES-1:0][7:0] rd_line;
   logic [LANES-1:0]      lane_we;

   logic [127:0]      dat_s_q;

   assign req = bus.CYC && bus.STB;

   // state and counter registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= 8'd0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   // next-state: accept in IDLE, count down in WAIT, abort on CYC loss
   always_comb begin
      state_nx   = state;
      cnt_nx     = cnt;
      accept     = 1'b0;
      enter_done = 1'b0;
      case (state)
         IDLE: begin
            if (req) begin
               accept = 1'b1;
               cnt_nx = 8'(LATENCY - 1);
               if (LATENCY > 1) begin
                  state_nx = WAIT;
               end else begin
                  state_nx   = DONE;
                  enter_done = 1'b1;
               end
            end
         end
         WAIT: begin
            if (!bus.CYC) begin
               state_nx = IDLE;
               cnt_nx   = 8'd0;
            end else begin
               cnt_nx = cnt - 8'd1;
               if (cnt == 8'd1) begin
                  state_nx   = DONE;
                  enter_done = 1'b1;
               end
            end
         end
         DONE: begin
            state_nx = IDLE;
            cnt_nx   = 8'd0;
         end
         default: begin
            state_nx = IDLE;
            cnt_nx   = 8'd0;
         end
      endcase
   end

   // capture the request so later bus changes cannot disturb it
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lat_we  <= 1'b0;
         lat_adr <= '0;
         lat_sel <= '0;
         lat_dat <= '0;
      end else if (accept) begin
         lat_we  <= bus.WE;
         lat_adr <= bus.ADR;
         lat_sel <= bus.SEL;
         lat_dat <= bus.DAT_M;
      end
   end

   // select live or latched request fields
   always_comb begin
      op_we  = accept ? bus.WE    : lat_we;
      op_adr = accept ? bus.ADR   : lat_adr;
      op_sel = accept ? bus.SEL   : lat_sel;
      op_dat = accept ? bus.DAT_M : lat_dat;
   end

   assign lane_we = (enter_done && op_we) ? op_sel : '0;

   genvar g;
   generate
      for (g = 0; g < LANES; g++) begin : g_lane
         pmem_byte_lane #(.ADDR_W(ADDR_W)) u_lane (
            .clk   (clk),
            .we    (lane_we[g]),
            .adr   (op_adr),
            .wdata (op_dat[g]),
            .rdata (rd_line[g])
         );
      end
   endgenerate

   // read data register: loaded only when a read enters DONE
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                       dat_s_q <= 128'h0;
      else if (enter_done && !op_we) dat_s_q <= rd_line;
   end

   assign bus.DAT_S = dat_s_q;
   assign bus.ACK   = (state == DONE);
   assign bus.busy  = (state != IDLE);
endmodule
